// File: rtl/dw_denorm_seq_if.sv
// Operand/result handshake bundle for the sequential denormalizer.
// slave is the denormalizer's view; master is the producer/consumer side.
interface dw_denorm_seq_if #(
  parameter int a_width   = 8,
  parameter int exp_width = 4
);
  logic                 in_valid;
  logic                 in_ready;
  logic [a_width-1:0]   a;
  logic [exp_width-1:0] exp_in;
  logic [exp_width-1:0] exp_target;
  logic                 out_valid;
  logic                 out_ready;
  logic [a_width-1:0]   b;
  logic [exp_width-1:0] exp_out;
  logic                 sticky;
  logic                 zero;

  modport slave (
    input  in_valid, a, exp_in, exp_target, out_ready,
    output in_ready, out_valid, b, exp_out, sticky, zero
  );

  modport master (
    output in_valid, a, exp_in, exp_target, out_ready,
    input  in_ready, out_valid, b, exp_out, sticky, zero
  );
endinterface

// File: rtl/dw_denorm_seq.sv
// Iterative right-shift denormalizer, step bits/cycle; sticky logic only with DW_DENORM_STICKY_EN.
// Latency: accept edge plus ceil(cnt/step) shift edges; holds DONE while out_ready is low, in_ready only in IDLE.
module dw_denorm_seq #(
  parameter int a_width   = 8,
  parameter int exp_width = 4,
  parameter int step      = 2
) (
  input  logic           clk,
  input  logic           rst,
  dw_denorm_seq_if.slave bus
);
  localparam int CW = $clog2(a_width + 1);
  localparam int MW = ((exp_width > CW) ? exp_width : CW) + 1;
  localparam logic [CW-1:0] STEP_C = CW'(step);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t               state, state_nxt;
  logic [a_width-1:0]   b_q, b_nxt;
  logic [CW-1:0]        cnt_q, cnt_nxt;
  logic [exp_width-1:0] exp_q, exp_nxt;
  logic [exp_width-1:0] shamt;
  logic [CW-1:0]        cnt_init;
  logic [CW-1:0]        k;
  logic                 accept;

  assign accept = (state == IDLE) && bus.in_valid;

  // Shifts of a_width or more saturate to a full shift-out.
  always_comb begin
    shamt    = (bus.exp_target > bus.exp_in) ? (bus.exp_target - bus.exp_in) : '0;
    cnt_init = (MW'(shamt) > MW'(a_width)) ? CW'(a_width) : CW'(shamt);
    k        = (cnt_q < STEP_C) ? cnt_q : STEP_C;
  end

  always_comb begin
    state_nxt = state;
    b_nxt     = b_q;
    cnt_nxt   = cnt_q;
    exp_nxt   = exp_q;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          b_nxt     = bus.a;
          cnt_nxt   = cnt_init;
          exp_nxt   = (bus.exp_in > bus.exp_target) ? bus.exp_in : bus.exp_target;
          state_nxt = (cnt_init == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        b_nxt   = b_q >> k;
        cnt_nxt = cnt_q - k;
        if (cnt_q <= STEP_C) state_nxt = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      b_q   <= '0;
      cnt_q <= '0;
      exp_q <= '0;
    end else begin
      state <= state_nxt;
      b_q   <= b_nxt;
      cnt_q <= cnt_nxt;
      exp_q <= exp_nxt;
    end
  end

`ifdef DW_DENORM_STICKY_EN
  logic [a_width-1:0] out_mask;
  logic               sticky_q;

  // Bits about to fall off the LSB end in this SHIFT cycle.
  assign out_mask = ~({a_width{1'b1}} << k);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_q <= 1'b0;
    end else if (accept) begin
      sticky_q <= 1'b0;
    end else if (state == SHIFT) begin
      sticky_q <= sticky_q | (|(b_q & out_mask));
    end
  end

  assign bus.sticky = sticky_q;
`else
  assign bus.sticky = 1'b0;
`endif

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.b         = b_q;
  assign bus.exp_out   = exp_q;
  assign bus.zero      = (b_q == '0);
endmodule

// File: tb/tb_dw_denorm_seq.sv
// Directed plus randomized checks of dw_denorm_seq (8/4/2) against an arithmetic reference model.
// The model divides by 2**shift for b and uses the remainder for sticky.
module tb_dw_denorm_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

`ifdef DW_DENORM_STICKY_EN
  localparam bit STICKY_EN = 1'b1;
`else
  localparam bit STICKY_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  dw_denorm_seq_if #(.a_width(8), .exp_width(4)) bus ();

  dw_denorm_seq #(.a_width(8), .exp_width(4), .step(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"},  32'(bus.in_ready),  32'd1);
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_b"},         32'(bus.b),         32'd0);
    chk({tag, "_exp_out"},   32'(bus.exp_out),   32'd0);
    chk({tag, "_sticky"},    32'(bus.sticky),    32'd0);
    chk({tag, "_zero"},      32'(bus.zero),      32'd1);
  endtask

  // Caller is positioned at a negedge with the DUT idle; returns at a negedge, DUT idle again.
  task automatic op(input logic [7:0] a, input logic [3:0] ei, input logic [3:0] et,
                    input int hold, input string tag);
    int          sh;
    int          lat;
    int          exp_lat;
    logic [7:0]  eb;
    logic [3:0]  eexp;
    logic        est;
    logic [7:0]  hb;
    logic [3:0]  hexp;
    logic        hst;
    sh      = (int'(et) > int'(ei)) ? int'(et) - int'(ei) : 0;
    if (sh > 8) sh = 8;
    eb      = 8'(int'(a) / (1 << sh));
    est     = STICKY_EN && ((int'(a) % (1 << sh)) != 0);
    eexp    = (ei > et) ? ei : et;
    exp_lat = (sh == 0) ? 1 : 1 + (sh + 1) / 2;

    chk({tag, "_idle_in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.a = a; bus.exp_in = ei; bus.exp_target = et;
    bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.a = 8'($urandom); bus.exp_in = 4'($urandom); bus.exp_target = 4'($urandom);
    chk({tag, "_busy_in_ready"}, 32'(bus.in_ready), 32'd0);
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    chk({tag, "_latency"}, 32'(lat),         32'(exp_lat));
    chk({tag, "_b"},       32'(bus.b),       32'(eb));
    chk({tag, "_sticky"},  32'(bus.sticky),  32'(est));
    chk({tag, "_exp_out"}, 32'(bus.exp_out), 32'(eexp));
    chk({tag, "_zero"},    32'(bus.zero),    32'(eb == 8'h00));

    hb = eb; hexp = eexp; hst = est;
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = ~bus.in_valid;
      bus.a = 8'($urandom); bus.exp_in = 4'($urandom); bus.exp_target = 4'($urandom);
      @(negedge clk);
      chk({tag, "_hold_out_valid"}, 32'(bus.out_valid), 32'd1);
      chk({tag, "_hold_in_ready"},  32'(bus.in_ready),  32'd0);
      chk({tag, "_hold_b"},         32'(bus.b),         32'(hb));
      chk({tag, "_hold_exp_out"},   32'(bus.exp_out),   32'(hexp));
      chk({tag, "_hold_sticky"},    32'(bus.sticky),    32'(hst));
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk({tag, "_release_in_ready"},  32'(bus.in_ready),  32'd1);
    chk({tag, "_release_out_valid"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.a = '0; bus.exp_in = '0; bus.exp_target = '0;
    #1;
    chk_reset_vals("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    op(8'hB1, 4'd3, 4'd6,  0, "midrange");
    op(8'hC0, 4'd5, 4'd2,  0, "passthru");
    op(8'h80, 4'd0, 4'd15, 0, "saturate");
    op(8'hF0, 4'd1, 4'd5,  0, "exact");
    op(8'hB1, 4'd4, 4'd4,  0, "equal_exp");
    op(8'hFF, 4'd2, 4'd9,  5, "backpressure");
    op(8'h81, 4'd0, 4'd7,  0, "shift7");

    // Saturation case interrupted by reset in its second SHIFT cycle.
    bus.a = 8'h80; bus.exp_in = 4'd0; bus.exp_target = 4'd15;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk_reset_vals("rst_mid_shift");
    @(negedge clk);
    rst = 1'b0;
    op(8'hC0, 4'd5, 4'd2, 0, "post_reset_passthru");

    for (int n = 0; n < 40; n++) begin
      op(8'($urandom), 4'($urandom), 4'($urandom), int'($urandom_range(0, 3)), "random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "simulation did not finish");
  end
endmodule
